// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC and keeps at most one instruction-memory request outstanding.
// It hands each returned word to decode with its PC and PC+4, and drops wrong-path data after a redirect.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        id_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc4
);

  localparam logic [1:0] S_FETCH   = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ipc4_q, ipc4_d;
  logic        valid_q, valid_d;
  logic        run_q;

  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign target   = redirect_target & ALIGN_MASK;
  assign pc_plus4 = pc_q + 32'd4;

  // run_q holds off the first request until one edge after reset release.
  assign imem_req    = run_q && (state_q == S_FETCH);
  assign imem_addr   = pc_q & ALIGN_MASK;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_pc4   = ipc4_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    valid_d = valid_q;
    case (state_q)
      S_FETCH: begin
        if (redirect_valid) pc_d = target;
        // A request accepted alongside a redirect is wrong-path: wait out its response.
        if (run_q && imem_ready) state_d = redirect_valid ? S_DISCARD : S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d    = target;
          state_d = imem_rvalid ? S_FETCH : S_DISCARD;
        end else if (imem_rvalid) begin
          instr_d = imem_rdata;
          ipc_d   = pc_q;
          ipc4_d  = pc_plus4;
          pc_d    = pc_plus4;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = target;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end else if (id_ready) begin
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_DISCARD: begin
        if (redirect_valid) pc_d = target;
        if (imem_rvalid) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC & ALIGN_MASK;
      instr_q <= 32'h0;
      ipc_q   <= 32'h0;
      ipc4_q  <= 32'h0;
      valid_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
      valid_q <= valid_d;
      run_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a table of straight-line fetches plus directed redirect/reset sequences.
// Delivered instructions are checked against a scoreboard queue by a negedge monitor.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          hold;
    logic [31:0] pc;
    logic [31:0] pc4;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  exp_t sb_q[$];

  instr_fetch_unit #(.RESET_PC(32'h0040_0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_ready        (id_ready),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_pc4       (instr_pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Monitor: pop on each new instruction, check stability while it is held.
  logic        prev_valid = 1'b0;
  logic [31:0] held_instr, held_pc, held_pc4;
  always @(negedge clk) begin
    if (instr_valid === 1'b1) begin
      if (!prev_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual=instr %h at pc %h required=none", instr, instr_pc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sb_instr", instr, e.data);
          chk("sb_pc", instr_pc, e.pc);
          chk("sb_pc4", instr_pc4, e.pc4);
          $display("txn pc=%h pc4=%h instr=%h", instr_pc, instr_pc4, instr);
        end
      end else begin
        chk("hold_instr", instr, held_instr);
        chk("hold_pc", instr_pc, held_pc);
        chk("hold_pc4", instr_pc4, held_pc4);
      end
      held_instr = instr;
      held_pc    = instr_pc;
      held_pc4   = instr_pc4;
    end
    prev_valid = instr_valid;
  end

  task automatic wait_req(input logic [31:0] exp_addr);
    for (int i = 0; i < 20 && imem_req !== 1'b1; i++) tick();
    chk("req_high", {31'b0, imem_req}, 32'd1);
    chk("req_addr", imem_addr, exp_addr);
  endtask

  task automatic fetch_one(input vec_t v);
    wait_req(v.pc);
    tick();
    chk("wait_noreq", {31'b0, imem_req}, 32'd0);
    for (int i = 1; i < v.lat; i++) tick();
    imem_rvalid = 1'b1;
    imem_rdata  = v.data;
    id_ready    = 1'b0;
    sb_q.push_back('{v.data, v.pc, v.pc4});
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    chk("valid_after_rvalid", {31'b0, instr_valid}, 32'd1);
    for (int i = 0; i < v.hold; i++) begin
      chk("hold_noreq", {31'b0, imem_req}, 32'd0);
      tick();
    end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    chk("valid_drop", {31'b0, instr_valid}, 32'd0);
    chk("refetch_req", {31'b0, imem_req}, 32'd1);
  endtask

  vec_t table_v[4];

  initial begin
    table_v[0] = '{32'h8C08_0000, 1, 0, 32'h0040_0000, 32'h0040_0004};
    table_v[1] = '{32'h0000_0020, 1, 0, 32'h0040_0004, 32'h0040_0008};
    table_v[2] = '{32'h2108_0001, 3, 5, 32'h0040_0008, 32'h0040_000C};
    table_v[3] = '{32'h1000_FFFF, 2, 1, 32'h0040_000C, 32'h0040_0010};

    rst_n = 1'b0;
    imem_ready = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    id_ready = 1'b0;

    // Reset behaviour and first request
    repeat (3) begin
      tick();
      chk("rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_req", {31'b0, imem_req}, 32'd0);
    end
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_pc4", instr_pc4, 32'h0);
    rst_n = 1'b1;
    #1 chk("rel_req0", {31'b0, imem_req}, 32'd0);
    tick();
    chk("rel_req1", {31'b0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'h0040_0000);

    // Straight-line run including a 5-cycle decode stall
    for (int i = 0; i < 4; i++) fetch_one(table_v[i]);

    // Redirect in WAIT, response two cycles later is dropped (target low bits ignored)
    wait_req(32'h0040_0010);
    tick();
    redirect_valid = 1'b1;
    redirect_target = 32'h0040_0103;
    tick();
    redirect_valid = 1'b0;
    chk("disc_noreq0", {31'b0, imem_req}, 32'd0);
    tick();
    chk("disc_noreq1", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    chk("disc_valid", {31'b0, instr_valid}, 32'd0);
    fetch_one('{32'h0C10_0040, 1, 0, 32'h0040_0100, 32'h0040_0104});

    // Redirect with rvalid in the same WAIT cycle
    wait_req(32'h0040_0104);
    tick();
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD0_0001;
    redirect_valid = 1'b1;
    redirect_target = 32'h0040_0200;
    tick();
    imem_rvalid = 1'b0;
    redirect_valid = 1'b0;
    chk("rw_valid", {31'b0, instr_valid}, 32'd0);
    chk("rw_req", {31'b0, imem_req}, 32'd1);
    chk("rw_addr", imem_addr, 32'h0040_0200);

    // Redirect in FETCH without and then with imem_ready
    imem_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h0040_0300;
    tick();
    redirect_valid = 1'b0;
    chk("fr_addr", imem_addr, 32'h0040_0300);
    tick();
    chk("fr_stable", imem_addr, 32'h0040_0300);
    chk("fr_req", {31'b0, imem_req}, 32'd1);
    imem_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h0040_0400;
    tick();
    redirect_valid = 1'b0;
    chk("frr_noreq", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD0_0002;
    tick();
    imem_rvalid = 1'b0;
    chk("frr_addr", imem_addr, 32'h0040_0400);

    // Redirect while holding a valid instruction
    wait_req(32'h0040_0400);
    tick();
    imem_rvalid = 1'b1;
    imem_rdata = 32'h3C01_1234;
    sb_q.push_back('{32'h3C01_1234, 32'h0040_0400, 32'h0040_0404});
    tick();
    imem_rvalid = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    chk("hr_valid", {31'b0, instr_valid}, 32'd0);
    chk("hr_addr", imem_addr, 32'hFFFF_FFFC);

    // PC wrap-around
    fetch_one('{32'h0800_0000, 1, 0, 32'hFFFF_FFFC, 32'h0000_0000});
    wait_req(32'h0000_0000);

    // Asynchronous reset mid-WAIT, late response ignored
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'b0, instr_valid}, 32'd0);
    chk("ar_req", {31'b0, imem_req}, 32'd0);
    chk("ar_instr", instr, 32'h0);
    chk("ar_pc", instr_pc, 32'h0);
    chk("ar_pc4", instr_pc4, 32'h0);
    tick();
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD0_0003;
    tick();
    rst_n = 1'b1;
    tick();
    imem_rvalid = 1'b0;
    chk("late_valid", {31'b0, instr_valid}, 32'd0);
    chk("late_req", {31'b0, imem_req}, 32'd1);
    chk("late_addr", imem_addr, 32'h0040_0000);
    fetch_one('{32'h2402_000A, 1, 0, 32'h0040_0000, 32'h0040_0004});

    repeat (3) tick();
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
